// File: rtl/blk_addr_alloc.sv
// blk_addr_alloc - free-list manager for SRAM block base addresses.
//
// Keeps a circular FIFO of free block indices. After reset an init sweep
// loads index i into entry i (one entry per cycle), then the list serves
// one-cycle allocation requests with one-cycle grants and accepts block
// returns from the output side. Requests that cannot be served at once are
// remembered in a small saturating pending counter.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_addr_req       one-cycle allocation request
//   o_blk_addr_vld   one-cycle grant strobe
//   o_blk_addr       granted block base address (low bits zero), 0 when idle
//   i_free_vld       one-cycle block return strobe
//   i_free_addr      returned block base address (low bits ignored)
//   o_init_done      free list populated after reset
//   o_free_cnt       number of free blocks
//   o_empty          no free blocks
//   o_err_ovf        sticky: return while list full and no same-cycle grant
//   o_err_req_ovf    sticky: request lost to pending counter saturation
//   o_err_dfree      sticky: return of a block not currently allocated
//                    (only when ALLOC_DFREE_CHECK_EN is defined)
//
// Optional feature macro: ALLOC_DFREE_CHECK_EN adds an allocated-block
// bitmap and drops returns of blocks that are not allocated.
//
// Handshake: requests, grants and returns are single-cycle strobes with no
// back-pressure; a request is never refused, it is held pending until a
// free block exists.
module blk_addr_alloc #(
    parameter int ADDR_W         = 11,
    parameter int BLK_WORDS_LOG2 = 4,
    parameter int PEND_W         = 2
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_addr_req,
    output logic                               o_blk_addr_vld,
    output logic [ADDR_W-1:0]                  o_blk_addr,
    input  logic                               i_free_vld,
    input  logic [ADDR_W-1:0]                  i_free_addr,
    output logic                               o_init_done,
    output logic [ADDR_W-BLK_WORDS_LOG2:0]     o_free_cnt,
    output logic                               o_empty,
`ifdef ALLOC_DFREE_CHECK_EN
    output logic                               o_err_dfree,
`endif
    output logic                               o_err_ovf,
    output logic                               o_err_req_ovf
);
    localparam int IDX_W   = ADDR_W - BLK_WORDS_LOG2;
    localparam int CNT_W   = IDX_W + 1;
    localparam int NUM_BLK = 1 << IDX_W;
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(NUM_BLK);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    mem [NUM_BLK];
    logic [IDX_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PEND_W-1:0]   pending_q, pending_d;
    logic                grant, push, mem_we;
    logic [IDX_W-1:0]    mem_wdata;
    logic [IDX_W-1:0]    free_idx;
    logic                dfree_bad;
    logic                err_ovf_set, err_req_set;
    logic                vld_q, empty_q, err_ovf_q, err_req_q;
    logic [ADDR_W-1:0]   addr_q;

    // Offset bits of a returned address carry no information.
    logic                unused_free_lsb;
    assign unused_free_lsb = &{1'b0, i_free_addr[BLK_WORDS_LOG2-1:0]};

    assign free_idx = i_free_addr[ADDR_W-1:BLK_WORDS_LOG2];

`ifdef ALLOC_DFREE_CHECK_EN
    logic [NUM_BLK-1:0] alloc_q;
    logic               err_dfree_q;
    assign dfree_bad   = (state_q == S_RUN) && i_free_vld && !alloc_q[free_idx];
    assign o_err_dfree = err_dfree_q;
`else
    assign dfree_bad = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        pending_d   = pending_q;
        grant       = 1'b0;
        push        = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        err_ovf_set = 1'b0;
        err_req_set = 1'b0;
        case (state_q)
            S_INIT: begin
                // Returns are ignored; requests only accumulate.
                mem_we    = 1'b1;
                mem_wdata = wr_ptr_q;
                wr_ptr_d  = wr_ptr_q + 1'b1;
                if (i_addr_req) begin
                    if (pending_q == PEND_MAX) err_req_set = 1'b1;
                    else                       pending_d   = pending_q + 1'b1;
                end
                if (wr_ptr_q == IDX_W'(NUM_BLK - 1)) begin
                    count_d = CNT_FULL;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                grant = ((pending_q != '0) || i_addr_req) && (count_q != '0);
                // A grant without a request only happens with pending != 0,
                // so the decrement cannot underflow.
                case ({i_addr_req, grant})
                    2'b10: begin
                        if (pending_q == PEND_MAX) err_req_set = 1'b1;
                        else                       pending_d   = pending_q + 1'b1;
                    end
                    2'b01:   pending_d = pending_q - 1'b1;
                    default: pending_d = pending_q;
                endcase
                // A same-cycle grant frees a slot, so a full list can still
                // accept the return. The read of mem[rd_ptr] sees the old
                // entry even when rd_ptr == wr_ptr.
                if (i_free_vld && !dfree_bad) begin
                    if ((count_q != CNT_FULL) || grant) push        = 1'b1;
                    else                                err_ovf_set = 1'b1;
                end
                if (push) begin
                    mem_we    = 1'b1;
                    mem_wdata = free_idx;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                end
                if (grant) rd_ptr_d = rd_ptr_q + 1'b1;
                count_d = count_q + CNT_W'(push) - CNT_W'(grant);
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) mem[wr_ptr_q] <= mem_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_INIT;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
            vld_q     <= 1'b0;
            addr_q    <= '0;
            empty_q   <= 1'b0;
            err_ovf_q <= 1'b0;
            err_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            vld_q     <= grant;
            addr_q    <= grant ? {mem[rd_ptr_q], {BLK_WORDS_LOG2{1'b0}}} : '0;
            // Empty is only meaningful once the list is live.
            empty_q   <= (state_d == S_RUN) && (count_d == '0);
            err_ovf_q <= err_ovf_q | err_ovf_set;
            err_req_q <= err_req_q | err_req_set;
        end
    end

`ifdef ALLOC_DFREE_CHECK_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            alloc_q     <= '0;
            err_dfree_q <= 1'b0;
        end else begin
            if (push)  alloc_q[free_idx]      <= 1'b0;
            if (grant) alloc_q[mem[rd_ptr_q]] <= 1'b1;
            err_dfree_q <= err_dfree_q | dfree_bad;
        end
    end
`endif

    assign o_blk_addr_vld = vld_q;
    assign o_blk_addr     = addr_q;
    assign o_init_done    = (state_q == S_RUN);
    assign o_free_cnt     = count_q;
    assign o_empty        = empty_q;
    assign o_err_ovf      = err_ovf_q;
    assign o_err_req_ovf  = err_req_q;

endmodule

// File: tb/tb_blk_addr_alloc.sv
// tb_blk_addr_alloc - directed bench for blk_addr_alloc.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_blk_addr_alloc;
    logic        clk;
    logic        rst_n;
    logic        addr_req;
    logic        blk_addr_vld;
    logic [10:0] blk_addr;
    logic        free_vld;
    logic [10:0] free_addr;
    logic        init_done;
    logic [7:0]  free_cnt;
    logic        empty;
    logic        err_ovf;
    logic        err_req_ovf;
`ifdef ALLOC_DFREE_CHECK_EN
    logic        err_dfree;
`endif

    int n_chk;
    int n_pass;

    blk_addr_alloc dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_addr_req     (addr_req),
        .o_blk_addr_vld (blk_addr_vld),
        .o_blk_addr     (blk_addr),
        .i_free_vld     (free_vld),
        .i_free_addr    (free_addr),
        .o_init_done    (init_done),
        .o_free_cnt     (free_cnt),
        .o_empty        (empty),
`ifdef ALLOC_DFREE_CHECK_EN
        .o_err_dfree    (err_dfree),
`endif
        .o_err_ovf      (err_ovf),
        .o_err_req_ovf  (err_req_ovf)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // One clock cycle with the given inputs; returns at the next falling edge.
    task automatic step(input logic req, input logic fv, input logic [10:0] fa);
        addr_req  = req;
        free_vld  = fv;
        free_addr = fa;
        @(negedge clk);
        addr_req  = 1'b0;
        free_vld  = 1'b0;
        free_addr = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 11'h0);
    endtask

    // Asserts reset, checks reset values asynchronously, releases on a
    // falling edge. The init sweep starts at the next rising edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_vld",      32'(blk_addr_vld), 32'd0);
        chk("rst_addr",     32'(blk_addr),     32'd0);
        chk("rst_init",     32'(init_done),    32'd0);
        chk("rst_cnt",      32'(free_cnt),     32'd0);
        chk("rst_empty",    32'(empty),        32'd0);
        chk("rst_ovf",      32'(err_ovf),      32'd0);
        chk("rst_req_ovf",  32'(err_req_ovf),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        addr_req  = 1'b0;
        free_vld  = 1'b0;
        free_addr = '0;
        @(negedge clk);

        // Init sweep length with no traffic.
        do_reset();
        idle(127);
        chk("init_not_yet", 32'(init_done), 32'd0);
        idle(1);
        chk("init_done_128", 32'(init_done), 32'd1);
        chk("init_cnt",      32'(free_cnt),  32'd128);
        chk("init_empty",    32'(empty),     32'd0);
        chk("init_vld",      32'(blk_addr_vld), 32'd0);

        // Requests during init become back-to-back grants afterwards.
        do_reset();
        idle(3);
        step(1'b1, 1'b0, 11'h0);
        idle(5);
        step(1'b1, 1'b1, 11'h100);   // return during init is ignored
        idle(118);
        chk("pend_init_done", 32'(init_done),    32'd1);
        chk("pend_no_vld",    32'(blk_addr_vld), 32'd0);
        chk("pend_cnt128",    32'(free_cnt),     32'd128);
        idle(1);
        chk("pend_g0_vld",  32'(blk_addr_vld), 32'd1);
        chk("pend_g0_addr", 32'(blk_addr),     32'h000);
        idle(1);
        chk("pend_g1_vld",  32'(blk_addr_vld), 32'd1);
        chk("pend_g1_addr", 32'(blk_addr),     32'h010);
        chk("pend_cnt126",  32'(free_cnt),     32'd126);
        idle(1);
        chk("pend_done_vld", 32'(blk_addr_vld), 32'd0);

        // Drain the whole list in order.
        do_reset();
        idle(128);
        for (int i = 0; i < 128; i++) begin
            step(1'b1, 1'b0, 11'h0);
            chk("drain_vld",  32'(blk_addr_vld), 32'd1);
            chk("drain_addr", 32'(blk_addr),     32'(i * 16));
            idle(1);
            chk("drain_gap",  32'(blk_addr_vld), 32'd0);
        end
        chk("drain_cnt",   32'(free_cnt), 32'd0);
        chk("drain_empty", 32'(empty),    32'd1);
        step(1'b1, 1'b0, 11'h0);
        chk("req129_vld", 32'(blk_addr_vld), 32'd0);
        idle(2);
        chk("req129_still", 32'(blk_addr_vld), 32'd0);
        step(1'b0, 1'b1, 11'h235);
        chk("free235_novld", 32'(blk_addr_vld), 32'd0);
        chk("free235_cnt",   32'(free_cnt),     32'd1);
        chk("free235_empty", 32'(empty),        32'd0);
        idle(1);
        chk("free235_vld",  32'(blk_addr_vld), 32'd1);
        chk("free235_addr", 32'(blk_addr),     32'h230);
        chk("free235_cnt0", 32'(free_cnt),     32'd0);
        chk("free235_ovf",  32'(err_ovf),      32'd0);

        // Pending saturation on an empty list.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 11'h0);
        chk("sat3_req_ovf", 32'(err_req_ovf), 32'd0);
        step(1'b1, 1'b0, 11'h0);
        chk("sat4_req_ovf", 32'(err_req_ovf),  32'd1);
        chk("sat4_vld",     32'(blk_addr_vld), 32'd0);
        step(1'b0, 1'b1, 11'h000);
        chk("sat_f0_vld", 32'(blk_addr_vld), 32'd0);
        step(1'b0, 1'b1, 11'h010);
        chk("sat_g0_vld",  32'(blk_addr_vld), 32'd1);
        chk("sat_g0_addr", 32'(blk_addr),     32'h000);
        step(1'b0, 1'b1, 11'h020);
        chk("sat_g1_vld",  32'(blk_addr_vld), 32'd1);
        chk("sat_g1_addr", 32'(blk_addr),     32'h010);
        idle(1);
        chk("sat_g2_vld",  32'(blk_addr_vld), 32'd1);
        chk("sat_g2_addr", 32'(blk_addr),     32'h020);
        chk("sat_cnt0",    32'(free_cnt),     32'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("sat_no_4th", 32'(blk_addr_vld), 32'd0);
        end

        // Returns against a full list; reset also clears sticky errors.
        do_reset();
        idle(128);
        step(1'b1, 1'b1, 11'h040);
        chk("full_req_vld",  32'(blk_addr_vld), 32'd1);
        chk("full_req_addr", 32'(blk_addr),     32'h000);
        chk("full_req_ovf",  32'(err_ovf),      32'd0);
`ifdef ALLOC_DFREE_CHECK_EN
        chk("full_req_cnt",  32'(free_cnt),  32'd127);
        chk("dfree_flag",    32'(err_dfree), 32'd1);
`else
        chk("full_req_cnt",  32'(free_cnt), 32'd128);
`endif
        step(1'b0, 1'b1, 11'h050);
        chk("full_free_vld", 32'(blk_addr_vld), 32'd0);
`ifdef ALLOC_DFREE_CHECK_EN
        chk("full_free_ovf", 32'(err_ovf),  32'd0);
        chk("full_free_cnt", 32'(free_cnt), 32'd127);
`else
        chk("full_free_ovf", 32'(err_ovf),  32'd1);
        chk("full_free_cnt", 32'(free_cnt), 32'd128);
`endif
        idle(3);
`ifndef ALLOC_DFREE_CHECK_EN
        chk("ovf_sticky", 32'(err_ovf), 32'd1);
`endif
        chk("full_empty", 32'(empty), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/blk_addr_alloc.md
Name: blk_addr_alloc

Overview:
Free-list manager that hands SRAM block base addresses to input_ctrl and takes them back from the output side once a block has been read out. It answers each one-cycle o_addr_req pulse from input_ctrl with a one-cycle i_blk_addr_vld / i_blk_addr grant. The SRAM is divided into 16-word blocks, so every granted address has its low 4 bits equal to zero. The block is a circular FIFO of free block indices, with a post-reset init sweep, a pending-request counter and error flags.

Parameters:
ADDR_W, 11, SRAM word address width; must equal `BLK_ADDR_WIDTH.
BLK_WORDS_LOG2, 4, log2 of words per block (16 words = 64 bytes).
NUM_BLK, 2**(ADDR_W-BLK_WORDS_LOG2) = 128, number of blocks managed.
PEND_W, 2, width of the pending-request counter (saturates at 3).

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_addr_req  in  1  one-cycle allocation request (input_ctrl o_addr_req)
o_blk_addr_vld  out  1  one-cycle grant strobe (to input_ctrl i_blk_addr_vld)
o_blk_addr  out  ADDR_W  granted block base address, low BLK_WORDS_LOG2 bits zero
i_free_vld  in  1  one-cycle block return strobe from the output side
i_free_addr  in  ADDR_W  returned block base address; low BLK_WORDS_LOG2 bits ignored
o_init_done  out  1  free list fully populated after reset
o_free_cnt  out  ADDR_W-BLK_WORDS_LOG2+1  number of free blocks
o_empty  out  1  o_free_cnt == 0
o_err_ovf  out  1  sticky: return attempted while list full
o_err_req_ovf  out  1  sticky: request arrived while pending counter saturated

Behaviour:
- Reset (i_rst_n asynchronous, active-low; clock i_clk): all outputs 0; rd_ptr = 0, wr_ptr = 0, count = 0, pending = 0; state = S_INIT.
- Storage: NUM_BLK x (ADDR_W-BLK_WORDS_LOG2) register array; rd_ptr and wr_ptr are log2(NUM_BLK) bits and wrap NUM_BLK-1 -> 0 naturally.
- FSM states: S_INIT, S_RUN.
- S_INIT:
  - One cycle per entry: writes index i to entry i for i = 0..NUM_BLK-1.
  - After the last write: count = NUM_BLK, wr_ptr wraps to 0, o_init_done = 1 from the next cycle, state -> S_RUN. S_INIT lasts exactly NUM_BLK cycles.
  - i_free_vld during S_INIT is ignored.
  - i_addr_req during S_INIT increments pending; no grant is issued.
- S_RUN, each cycle:
  - Request: pending_next = pending + i_addr_req - grant, saturating at 2**PEND_W-1. An increment lost to saturation sets o_err_req_ovf.
  - Grant condition: (pending != 0 || i_addr_req) && count != 0.
  - On grant, next cycle: o_blk_addr_vld = 1, o_blk_addr = {mem[rd_ptr], BLK_WORDS_LOG2'b0}; rd_ptr++.
  - Latency: request at cycle N with list non-empty and pending = 0 -> o_blk_addr_vld at N+1. input_ctrl needs a grant within 5 cycles of its wr_times==10 request.
  - Return: if i_free_vld && (count != NUM_BLK || grant this cycle), then mem[wr_ptr] = i_free_addr[ADDR_W-1:BLK_WORDS_LOG2]; wr_ptr++.
  - Return while full with no grant that cycle: dropped; o_err_ovf set (sticky until reset).
  - count_next = count + push - grant. A simultaneous grant and push leaves count unchanged.
  - Empty list plus same-cycle free and request: no bypass. The push lands this cycle, the request stays pending, and the grant is issued on the following cycle (vld at N+2).
- o_blk_addr is 0 whenever o_blk_addr_vld = 0.
- o_free_cnt and o_empty are registered and reflect count after the current cycle's updates.
- At most one grant per cycle; grants are issued in FIFO order of free-list contents.
- Reset asserted mid-operation: everything returns to reset values immediately, and the init sweep restarts after release.

Optional Feature:
ALLOC_DFREE_CHECK_EN
- Defined:
  - Adds a NUM_BLK-bit allocated bitmap, initialised to 0.
  - Grant sets the bit; an accepted return clears it.
  - A return whose bit is already 0 (double free or never allocated) is dropped and sets sticky output o_err_dfree (1 bit, reset 0).
- Undefined:
  - No bitmap and no o_err_dfree port; every return is pushed subject only to the full rule.

Test Plan:
- Reset release, no traffic -> o_init_done rises exactly 128 cycles later; o_free_cnt = 128; o_empty = 0.
- Two i_addr_req pulses during S_INIT -> back-to-back grants 0x000 and 0x010 on the first two cycles after o_init_done; o_free_cnt = 126.
- 128 requests, one every 2 cycles after init -> addresses 0x000, 0x010, ..., 0x7F0 in order; o_empty = 1. A 129th request -> no grant, pending = 1. Then i_free_vld with i_free_addr = 0x235 -> grant 0x230 two cycles after the free.
- Full list, i_free_vld with addr 0x040 -> o_err_ovf = 1, o_free_cnt stays 128. Same test with i_addr_req in the same cycle -> grant issued, free accepted, count stays 128, o_err_ovf stays 0.
- Pending saturation: empty list, 4 requests -> pending = 3, o_err_req_ovf = 1. Then 3 frees -> exactly 3 grants.
- With ALLOC_DFREE_CHECK_EN: after init, free 0x050 (never allocated) -> dropped, o_err_dfree = 1, o_free_cnt unchanged.
